// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter around one 32-bit ALU: operands are captured at grant; the result and flags return one cycle later.
// Define ALU_ARB_STATS_EN to add the saturating per-port grant counters stat_gnt_p0/stat_gnt_p1.
module alu_arbiter #(
  parameter bit PRIO_RESET = 1'b0
`ifdef ALU_ARB_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic [1:0]  ctrl_req,
  input  logic [4:0]  ctrl_ALUopcode_p0,
  input  logic [4:0]  ctrl_ALUopcode_p1,
  input  logic [4:0]  ctrl_shiftamt_p0,
  input  logic [4:0]  ctrl_shiftamt_p1,
  input  logic [31:0] data_operandA_p0,
  input  logic [31:0] data_operandA_p1,
  input  logic [31:0] data_operandB_p0,
  input  logic [31:0] data_operandB_p1,
  output logic [1:0]  ctrl_gnt,
  output logic [1:0]  ctrl_rvalid,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow,
  output logic        ctrl_busy
`ifdef ALU_ARB_STATS_EN
  , output logic [CNT_WIDTH-1:0] stat_gnt_p0,
  output logic [CNT_WIDTH-1:0] stat_gnt_p1
`endif
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2,
                         OP_OR  = 5'd3, OP_SLL = 5'd4, OP_SRA = 5'd5;

  alu_req_t [1:0] port_req;
  assign port_req[0] = {ctrl_ALUopcode_p0, ctrl_shiftamt_p0, data_operandA_p0, data_operandB_p0};
  assign port_req[1] = {ctrl_ALUopcode_p1, ctrl_shiftamt_p1, data_operandA_p1, data_operandB_p1};

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        win_q, win_d;
  alu_req_t    opnd_q, opnd_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] result_q, result_d;
  logic        ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d;

  // ALU works purely from the captured operand registers
  logic [31:0] sum, diff, alu_res;
  logic        add_ovf, sub_ovf, alu_ovf;

  always_comb begin
    sum     = opnd_q.a + opnd_q.b;
    diff    = opnd_q.a - opnd_q.b;
    add_ovf = (opnd_q.a[31] == opnd_q.b[31]) && (sum[31] != opnd_q.a[31]);
    sub_ovf = (opnd_q.a[31] != opnd_q.b[31]) && (diff[31] != opnd_q.a[31]);
    alu_res = sum;
    alu_ovf = add_ovf;
    case (opnd_q.op)
      OP_SUB:  begin alu_res = diff;                                alu_ovf = sub_ovf; end
      OP_AND:  begin alu_res = opnd_q.a & opnd_q.b;                 alu_ovf = 1'b0;    end
      OP_OR:   begin alu_res = opnd_q.a | opnd_q.b;                 alu_ovf = 1'b0;    end
      OP_SLL:  begin alu_res = opnd_q.a << opnd_q.shamt;            alu_ovf = 1'b0;    end
      OP_SRA:  begin alu_res = $signed(opnd_q.a) >>> opnd_q.shamt;  alu_ovf = 1'b0;    end
      default: begin alu_res = sum;                                 alu_ovf = add_ovf; end
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q  <= IDLE;
      prio_q   <= PRIO_RESET;
      win_q    <= 1'b0;
      opnd_q   <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      win_q    <= win_d;
      opnd_q   <= opnd_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next state and arbitration: a lone requester wins, a tie goes to prio
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (|ctrl_req) begin
        state_d = EXEC;
        win_d   = (&ctrl_req) ? prio_q : ctrl_req[1];
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    rvalid_d = '0;
    prio_d   = prio_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (|ctrl_req) begin
        gnt_d[win_d] = 1'b1;
        opnd_d       = port_req[win_d];
      end
      EXEC: begin
        rvalid_d[win_q] = 1'b1;
        prio_d          = ~win_q;
        result_d        = alu_res;
        ne_d            = (opnd_q.a != opnd_q.b);
        lt_d            = diff[31] ^ sub_ovf;
        ovf_d           = alu_ovf;
      end
      default: ;
    endcase
  end

  assign ctrl_gnt    = gnt_q;
  assign ctrl_rvalid = rvalid_q;
  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ovf_q;
  assign ctrl_busy   = (state_q == EXEC);

`ifdef ALU_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] stat_p0_q, stat_p0_d, stat_p1_q, stat_p1_d;

  // Counters step on the same edge that raises the grant, saturating at all-ones
  always_comb begin
    stat_p0_d = stat_p0_q;
    stat_p1_d = stat_p1_q;
    if (gnt_d[0] && (stat_p0_q != '1)) stat_p0_d = stat_p0_q + CNT_WIDTH'(1);
    if (gnt_d[1] && (stat_p1_q != '1)) stat_p1_d = stat_p1_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      stat_p0_q <= '0;
      stat_p1_q <= '0;
    end else begin
      stat_p0_q <= stat_p0_d;
      stat_p1_q <= stat_p1_d;
    end
  end

  assign stat_gnt_p0 = stat_p0_q;
  assign stat_gnt_p1 = stat_p1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, tie-break, alternation, operand capture, reset abort.
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic [1:0]  ctrl_req;
  logic [4:0]  ctrl_ALUopcode_p0, ctrl_ALUopcode_p1;
  logic [4:0]  ctrl_shiftamt_p0, ctrl_shiftamt_p1;
  logic [31:0] data_operandA_p0, data_operandA_p1;
  logic [31:0] data_operandB_p0, data_operandB_p1;
  logic [1:0]  ctrl_gnt, ctrl_rvalid;
  logic [31:0] data_result;
  logic        isNotEqual, isLessThan, overflow, ctrl_busy;
`ifdef ALU_ARB_STATS_EN
  logic [1:0]  stat_gnt_p0, stat_gnt_p1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

`ifdef ALU_ARB_STATS_EN
  alu_arbiter #(.PRIO_RESET(1'b0), .CNT_WIDTH(2)) dut (
`else
  alu_arbiter #(.PRIO_RESET(1'b0)) dut (
`endif
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .ctrl_req(ctrl_req),
    .ctrl_ALUopcode_p0(ctrl_ALUopcode_p0), .ctrl_ALUopcode_p1(ctrl_ALUopcode_p1),
    .ctrl_shiftamt_p0(ctrl_shiftamt_p0), .ctrl_shiftamt_p1(ctrl_shiftamt_p1),
    .data_operandA_p0(data_operandA_p0), .data_operandA_p1(data_operandA_p1),
    .data_operandB_p0(data_operandB_p0), .data_operandB_p1(data_operandB_p1),
    .ctrl_gnt(ctrl_gnt), .ctrl_rvalid(ctrl_rvalid), .data_result(data_result),
    .isNotEqual(isNotEqual), .isLessThan(isLessThan), .overflow(overflow),
    .ctrl_busy(ctrl_busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_gnt_p0(stat_gnt_p0), .stat_gnt_p1(stat_gnt_p1)
`endif
  );

  // Advance one edge and settle past it before sampling or driving
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_p0(input logic [4:0] op, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    ctrl_ALUopcode_p0 = op; ctrl_shiftamt_p0 = sh; data_operandA_p0 = a; data_operandB_p0 = b;
  endtask

  task automatic set_p1(input logic [4:0] op, input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    ctrl_ALUopcode_p1 = op; ctrl_shiftamt_p1 = sh; data_operandA_p1 = a; data_operandB_p1 = b;
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    tick();
    tick();
    ctrl_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ctrl_req = 2'b00;
    set_p0(5'd0, 5'd0, 32'h0, 32'h0);
    set_p1(5'd0, 5'd0, 32'h0, 32'h0);
    ctrl_reset_n = 1'b0;
    tick();
    checks++; if (ctrl_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", ctrl_gnt); end
    checks++; if (ctrl_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b want=00", ctrl_rvalid); end
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", data_result); end
    checks++; if ({isNotEqual, isLessThan, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {isNotEqual, isLessThan, overflow}); end
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", ctrl_busy); end
    ctrl_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_p0(5'd0, 5'd0, 32'h7FFFFFFF, 32'h1);
    ctrl_req = 2'b01;
    tick();
    checks++; if (ctrl_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b want=01", ctrl_gnt); end
    checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", ctrl_busy); end
    checks++; if (ctrl_rvalid !== 2'b00) begin errors++; $display("FAIL single_early_rvalid got=%b want=00", ctrl_rvalid); end
    ctrl_req = 2'b00;
    tick();
    checks++; if (ctrl_rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b want=01", ctrl_rvalid); end
    checks++; if (ctrl_gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_clear got=%b want=00", ctrl_gnt); end
    checks++; if (data_result !== 32'h80000000) begin errors++; $display("FAIL single_result got=%h want=80000000", data_result); end
    checks++; if ({isNotEqual, isLessThan, overflow} !== 3'b101) begin errors++; $display("FAIL single_flags ne/lt/ov got=%b want=101", {isNotEqual, isLessThan, overflow}); end
    tick();
    checks++; if (ctrl_rvalid !== 2'b00) begin errors++; $display("FAIL single_rvalid_pulse got=%b want=00", ctrl_rvalid); end
    checks++; if (data_result !== 32'h80000000) begin errors++; $display("FAIL single_result_hold got=%h want=80000000", data_result); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_p0(5'd1, 5'd0, 32'd5, 32'd9);
    set_p1(5'd4, 5'd4, 32'h1, 32'h0);
    ctrl_req = 2'b11;
    tick();
    checks++; if (ctrl_gnt !== 2'b01) begin errors++; $display("FAIL sim_gnt0 got=%b want=01", ctrl_gnt); end
    tick();
    checks++; if (ctrl_rvalid !== 2'b01) begin errors++; $display("FAIL sim_rvalid0 got=%b want=01", ctrl_rvalid); end
    checks++; if (data_result !== 32'hFFFFFFFC) begin errors++; $display("FAIL sim_result0 got=%h want=FFFFFFFC", data_result); end
    checks++; if (isLessThan !== 1'b1) begin errors++; $display("FAIL sim_lt0 got=%b want=1", isLessThan); end
    ctrl_req = 2'b10;
    tick();
    checks++; if (ctrl_gnt !== 2'b10) begin errors++; $display("FAIL sim_gnt1 got=%b want=10", ctrl_gnt); end
    ctrl_req = 2'b00;
    tick();
    checks++; if (ctrl_rvalid !== 2'b10) begin errors++; $display("FAIL sim_rvalid1 got=%b want=10", ctrl_rvalid); end
    checks++; if (data_result !== 32'h00000010) begin errors++; $display("FAIL sim_result1 got=%h want=00000010", data_result); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  want_port;
    logic [31:0] want_res;
    // prio is 0 here: the previous op completed on port 1
    set_p0(5'd0, 5'd0, 32'd1, 32'd2);
    set_p1(5'd3, 5'd0, 32'hF0, 32'h0F);
    ctrl_req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      want_port = (i % 2 == 0) ? 2'b01 : 2'b10;
      want_res  = (i % 2 == 0) ? 32'd3 : 32'hFF;
      tick();
      checks++; if (ctrl_gnt !== want_port || ctrl_rvalid !== 2'b00) begin
        errors++; $display("FAIL b2b_gnt[%0d] got gnt=%b rvalid=%b want gnt=%b rvalid=00", i, ctrl_gnt, ctrl_rvalid, want_port);
      end
      tick();
      checks++; if (ctrl_rvalid !== want_port || ctrl_gnt !== 2'b00 || data_result !== want_res) begin
        errors++; $display("FAIL b2b_rvalid[%0d] got rvalid=%b gnt=%b res=%h want rvalid=%b gnt=00 res=%h", i, ctrl_rvalid, ctrl_gnt, data_result, want_port, want_res);
      end
    end
    ctrl_req = 2'b00;
    tick();
  endtask

  task automatic test_operand_change();
    set_p1(5'd2, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    ctrl_req = 2'b10;
    tick();
    checks++; if (ctrl_gnt !== 2'b10) begin errors++; $display("FAIL opchg_gnt got=%b want=10", ctrl_gnt); end
    set_p1(5'd0, 5'd0, 32'h0, 32'h0);
    ctrl_req = 2'b00;
    tick();
    checks++; if (ctrl_rvalid !== 2'b10) begin errors++; $display("FAIL opchg_rvalid got=%b want=10", ctrl_rvalid); end
    checks++; if (data_result !== 32'hF000F000) begin errors++; $display("FAIL opchg_result got=%h want=F000F000", data_result); end
    tick();
  endtask

  task automatic test_reset_mid_exec();
    // Complete a port-0 op so prio moves to 1 and data_result is nonzero
    set_p0(5'd0, 5'd0, 32'd40, 32'd2);
    ctrl_req = 2'b01;
    tick();
    ctrl_req = 2'b00;
    tick();
    checks++; if (data_result !== 32'd42) begin errors++; $display("FAIL abort_setup_result got=%h want=0000002a", data_result); end
    ctrl_req = 2'b01;
    tick();
    checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL abort_busy got=%b want=1", ctrl_busy); end
    ctrl_req = 2'b00;
    #2 ctrl_reset_n = 1'b0;
    #1;
    checks++; if ({ctrl_gnt, ctrl_rvalid, ctrl_busy} !== 5'b0 || data_result !== 32'h0 || {isNotEqual, isLessThan, overflow} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs got gnt=%b rvalid=%b busy=%b res=%h flags=%b want all 0", ctrl_gnt, ctrl_rvalid, ctrl_busy, data_result, {isNotEqual, isLessThan, overflow});
    end
    tick();
    checks++; if (ctrl_rvalid !== 2'b00) begin errors++; $display("FAIL abort_no_rvalid got=%b want=00", ctrl_rvalid); end
    ctrl_reset_n = 1'b1;
    tick();
    // Tie must go to port 0 again because prio returned to PRIO_RESET
    set_p0(5'd0, 5'd0, 32'd1, 32'd1);
    set_p1(5'd0, 5'd0, 32'd2, 32'd2);
    ctrl_req = 2'b11;
    tick();
    checks++; if (ctrl_gnt !== 2'b01) begin errors++; $display("FAIL abort_prio_gnt got=%b want=01", ctrl_gnt); end
    ctrl_req = 2'b00;
    tick();
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_p0(5'd0, 5'd0, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      ctrl_req = 2'b01;
      tick();
      ctrl_req = 2'b00;
      tick();
    end
    checks++; if (stat_gnt_p0 !== 2'd3) begin errors++; $display("FAIL stat_p0 got=%0d want=3", stat_gnt_p0); end
    checks++; if (stat_gnt_p1 !== 2'd0) begin errors++; $display("FAIL stat_p1 got=%0d want=0", stat_gnt_p1); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_reset_n = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_operand_change();
    test_reset_mid_exec();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
